// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame identity filter.
package uart_pkg;

    // Frame parser states: M = matched frame, S = skipped frame.
    typedef enum logic [2:0] {
        StIdle,
        StLenM,
        StLenS,
        StPayM,
        StPayS
    } state_e;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_id_filter_if.sv
// Byte stream in, filtered payload and frame status out.
interface uart_id_filter_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_IDS = 4
) ();
    localparam int unsigned IDX_W = (NUM_IDS > 1) ? clog2(NUM_IDS) : 1;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              flag;
    logic              bcast;
    logic [IDX_W-1:0]  match_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frame_done;
    logic              frame_abort;

    // master: the byte source / status consumer
    modport master (
        output rx_data, rx_valid,
        input  flag, bcast, match_idx, out_data, out_valid, frame_done, frame_abort
    );

    // slave: the filter itself
    modport slave (
        input  rx_data, rx_valid,
        output flag, bcast, match_idx, out_data, out_valid, frame_done, frame_abort
    );
endinterface

// File: rtl/uart_id_match.sv
// Combinational priority matcher: broadcast first, then lowest enabled table entry.
module uart_id_match
    import uart_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       NUM_IDS  = 4,
    parameter logic [DATA_W-1:0] BCAST_ID = 8'hFF,
    localparam int unsigned      IDX_W    = (NUM_IDS > 1) ? clog2(NUM_IDS) : 1
) (
    input  logic [NUM_IDS*DATA_W-1:0] i_id_table,
    input  logic [NUM_IDS-1:0]        i_id_en,
    input  logic [DATA_W-1:0]         i_byte,
    output logic                      o_hit,
    output logic                      o_bcast,
    output logic [IDX_W-1:0]          o_idx
);

    // Scan from the top down so the lowest matching index is the last written.
    always_comb begin
        o_hit   = 1'b0;
        o_bcast = 1'b0;
        o_idx   = '0;
        if (i_byte == BCAST_ID) begin
            o_hit   = 1'b1;
            o_bcast = 1'b1;
        end else begin
            for (int i = NUM_IDS - 1; i >= 0; i--) begin
                if (i_id_en[i] && (i_id_table[i*DATA_W +: DATA_W] == i_byte)) begin
                    o_hit = 1'b1;
                    o_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_id_filter.sv
// Frame parser [ID][LEN][payload]: forwards payload of matching frames, aborts on idle timeout.
module uart_id_filter
    import uart_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       NUM_IDS     = 4,
    parameter logic [DATA_W-1:0] BCAST_ID    = 8'hFF,
    parameter int unsigned       TIMEOUT_CYC = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IDS*DATA_W-1:0] id_table,
    input  logic [NUM_IDS-1:0]        id_en,
    uart_id_filter_if.slave           bus
);

    localparam int unsigned      IDX_W    = (NUM_IDS > 1) ? clog2(NUM_IDS) : 1;
    localparam int unsigned      CNT_W    = clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    state_e             r_state, w_state_d;
    logic [DATA_W-1:0]  r_remaining, w_remaining_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic               r_flag, w_flag_d;
    logic               r_bcast, w_bcast_d;
    logic [IDX_W-1:0]   r_idx, w_idx_d;
    logic [DATA_W-1:0]  r_out_data, w_out_data_d;
    logic               r_out_valid, w_out_valid_d;
    logic               r_done, w_done_d;
    logic               r_abort, w_abort_d;

    logic               w_m_hit;
    logic               w_m_bcast;
    logic [IDX_W-1:0]   w_m_idx;

    uart_id_match #(
        .DATA_W  (DATA_W),
        .NUM_IDS (NUM_IDS),
        .BCAST_ID(BCAST_ID)
    ) u_match (
        .i_id_table(id_table),
        .i_id_en   (id_en),
        .i_byte    (bus.rx_data),
        .o_hit     (w_m_hit),
        .o_bcast   (w_m_bcast),
        .o_idx     (w_m_idx)
    );

    // Next-state, counters and registered-output next values.
    always_comb begin
        w_state_d     = r_state;
        w_remaining_d = r_remaining;
        w_cnt_d       = r_cnt;
        w_flag_d      = r_flag;
        w_bcast_d     = r_bcast;
        w_idx_d       = r_idx;
        w_out_data_d  = r_out_data;
        w_out_valid_d = 1'b0;
        w_done_d      = 1'b0;
        w_abort_d     = 1'b0;

        if (r_state == StIdle) begin
            w_cnt_d = '0;
            if (bus.rx_valid) begin
                if (w_m_hit) begin
                    w_bcast_d = w_m_bcast;
                    w_idx_d   = w_m_idx;
                    w_state_d = StLenM;
                end else begin
                    w_state_d = StLenS;
                end
            end
        end else if (bus.rx_valid) begin
            // A byte arriving on the expiry cycle wins over the timeout.
            w_cnt_d = '0;
            case (r_state)
                StLenM: begin
                    w_remaining_d = bus.rx_data;
                    if (bus.rx_data == '0) begin
                        w_done_d  = 1'b1;
                        w_bcast_d = 1'b0;
                        w_state_d = StIdle;
                    end else begin
                        w_flag_d  = 1'b1;
                        w_state_d = StPayM;
                    end
                end
                StLenS: begin
                    w_remaining_d = bus.rx_data;
                    w_state_d     = (bus.rx_data == '0) ? StIdle : StPayS;
                end
                StPayM: begin
                    w_out_data_d  = bus.rx_data;
                    w_out_valid_d = 1'b1;
                    w_remaining_d = r_remaining - 1'b1;
                    if (r_remaining == DATA_W'(1)) begin
                        w_done_d  = 1'b1;
                        w_flag_d  = 1'b0;
                        w_bcast_d = 1'b0;
                        w_state_d = StIdle;
                    end
                end
                StPayS: begin
                    w_remaining_d = r_remaining - 1'b1;
                    if (r_remaining == DATA_W'(1)) begin
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end else if (r_cnt == CNT_LAST) begin
            w_abort_d = 1'b1;
            w_flag_d  = 1'b0;
            w_bcast_d = 1'b0;
            w_idx_d   = '0;
            w_cnt_d   = '0;
            w_state_d = StIdle;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_cnt       <= '0;
            r_flag      <= 1'b0;
            r_bcast     <= 1'b0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_remaining <= w_remaining_d;
            r_cnt       <= w_cnt_d;
            r_flag      <= w_flag_d;
            r_bcast     <= w_bcast_d;
            r_idx       <= w_idx_d;
            r_out_data  <= w_out_data_d;
            r_out_valid <= w_out_valid_d;
            r_done      <= w_done_d;
            r_abort     <= w_abort_d;
        end
    end

    assign bus.flag        = r_flag;
    assign bus.bcast       = r_bcast;
    assign bus.match_idx   = r_idx;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.frame_done  = r_done;
    assign bus.frame_abort = r_abort;

endmodule

// File: tb/tb_uart_id_filter.sv
// Bench for uart_id_filter: directed frames plus random byte streams against a frame model.
module tb_uart_id_filter;
    import uart_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned NI = 4;
    localparam int unsigned TO = 20;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [DW-1:0]   tbl [NI];
    logic [NI-1:0]   id_en;
    logic [NI*DW-1:0] id_table;

    assign id_table = {tbl[3], tbl[2], tbl[1], tbl[0]};

    uart_id_filter_if #(.DATA_W(DW), .NUM_IDS(NI)) bus ();

    uart_id_filter #(
        .DATA_W     (DW),
        .NUM_IDS    (NI),
        .BCAST_ID   (8'hFF),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .id_table(id_table),
        .id_en   (id_en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: where we are in the frame, and what the outputs should read.
    int     m_phase;   // 0 = expect ID, 1 = expect LEN, 2 = payload
    bit     m_match;
    int     m_left;
    int     m_quiet;
    bit     e_flag, e_bcast, e_valid, e_done, e_abort;
    int     e_idx;
    logic [7:0] e_data;

    // Observed event counters for frame-level checks.
    int     obs_fwd, obs_done, obs_abort;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_lookup(input logic [7:0] d, output bit hit, output bit bc,
                                       output int idx);
        hit = 0;
        bc  = 0;
        idx = 0;
        if (d == 8'hFF) begin
            hit = 1;
            bc  = 1;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (!hit && id_en[i] && tbl[i] == d) begin
                    hit = 1;
                    idx = i;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_match = 0; m_left = 0; m_quiet = 0;
        e_flag = 0; e_bcast = 0; e_valid = 0; e_done = 0; e_abort = 0;
        e_idx = 0; e_data = 8'h00;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] d);
        bit hit, bc;
        int idx;
        e_valid = 0; e_done = 0; e_abort = 0;
        if (m_phase == 0) begin
            if (v) begin
                ref_lookup(d, hit, bc, idx);
                m_match = hit;
                if (hit) begin
                    e_bcast = bc;
                    e_idx   = idx;
                end
                m_phase = 1;
                m_quiet = 0;
            end
        end else if (v) begin
            m_quiet = 0;
            if (m_phase == 1) begin
                m_left = int'(d);
                if (d == 8'h00) begin
                    if (m_match) begin
                        e_done  = 1;
                        e_bcast = 0;
                    end
                    m_phase = 0;
                end else begin
                    if (m_match) e_flag = 1;
                    m_phase = 2;
                end
            end else begin
                if (m_match) begin
                    e_data  = d;
                    e_valid = 1;
                end
                m_left--;
                if (m_left == 0) begin
                    m_phase = 0;
                    if (m_match) begin
                        e_done  = 1;
                        e_flag  = 0;
                        e_bcast = 0;
                    end
                end
            end
        end else begin
            m_quiet++;
            if (m_quiet == TO) begin
                e_abort = 1;
                e_flag  = 0;
                e_bcast = 0;
                e_idx   = 0;
                m_phase = 0;
                m_quiet = 0;
            end
        end
    endfunction

    task automatic check_all();
        check_eq("flag",        32'(bus.flag),        32'(e_flag));
        check_eq("bcast",       32'(bus.bcast),       32'(e_bcast));
        check_eq("match_idx",   32'(bus.match_idx),   32'(e_idx));
        check_eq("out_valid",   32'(bus.out_valid),   32'(e_valid));
        check_eq("out_data",    32'(bus.out_data),    32'(e_data));
        check_eq("frame_done",  32'(bus.frame_done),  32'(e_done));
        check_eq("frame_abort", 32'(bus.frame_abort), 32'(e_abort));
    endtask

    // One clock: drive, let the edge happen, advance the model, compare 1 time unit later.
    task automatic step(input bit v, input logic [7:0] d);
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        model_step(v, d);
        #1;
        check_all();
        if (bus.out_valid)   obs_fwd++;
        if (bus.frame_done)  obs_done++;
        if (bus.frame_abort) obs_abort++;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic clear_obs();
        obs_fwd = 0; obs_done = 0; obs_abort = 0;
    endtask

    // Asynchronous reset in the middle of a cycle.
    task automatic async_reset();
        bus.rx_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
    endtask

    initial begin
        bit  bc_dummy;
        int  len, gap, pick;
        logic [7:0] id;

        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        for (int i = 0; i < NI; i++) tbl[i] = 8'h00;
        id_en = '0;
        model_reset();
        clear_obs();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // Table match
        tbl[0] = 8'h10; tbl[1] = 8'h20; tbl[2] = 8'h30; tbl[3] = 8'h40;
        id_en = 4'hF;
        clear_obs();
        send(8'h20); send(8'h03);
        check_eq("t1_flag_at_len", 32'(bus.flag), 32'd1);
        send(8'hA1); send(8'hA2); send(8'hA3);
        idle(1);
        check_eq("t1_fwd", 32'(obs_fwd), 32'd3);
        check_eq("t1_done", 32'(obs_done), 32'd1);
        check_eq("t1_idx", 32'(bus.match_idx), 32'd1);

        // Miss on disabled entry, then a hit on entry 0
        id_en = 4'b1101;
        clear_obs();
        send(8'h20); send(8'h02); send(8'hB1); send(8'hB2);
        check_eq("t2_miss_fwd", 32'(obs_fwd), 32'd0);
        send(8'h10); send(8'h01); send(8'hC1);
        check_eq("t2_hit_fwd", 32'(obs_fwd), 32'd1);
        check_eq("t2_data", 32'(bus.out_data), 32'hC1);

        // Broadcast, then zero-length frame
        clear_obs();
        send(8'hFF); send(8'h02);
        check_eq("t3_bcast", 32'(bus.bcast), 32'd1);
        send(8'hD1); send(8'hD2);
        send(8'h10); send(8'h00);
        check_eq("t3_fwd", 32'(obs_fwd), 32'd2);
        check_eq("t3_done", 32'(obs_done), 32'd2);

        // Timeout
        id_en = 4'hF;
        clear_obs();
        send(8'h10); send(8'h04); send(8'hE1);
        idle(TO - 1);
        check_eq("t4_no_early_abort", 32'(obs_abort), 32'd0);
        idle(1);
        check_eq("t4_abort_at_20", 32'(bus.frame_abort), 32'd1);
        send(8'h30);
        check_eq("t4_new_id_idx", 32'(bus.match_idx), 32'd2);
        send(8'h00);

        // Byte lands on the expiry cycle
        clear_obs();
        send(8'h10); send(8'h02); send(8'hE1);
        idle(TO - 1);
        send(8'hE2);
        check_eq("t5_race_no_abort", 32'(obs_abort), 32'd0);
        check_eq("t5_race_fwd", 32'(obs_fwd), 32'd2);

        // Priority among duplicate entries, then reset mid-payload
        tbl[1] = 8'h55; tbl[3] = 8'h55;
        send(8'h55);
        check_eq("t6_prio_idx", 32'(bus.match_idx), 32'd1);
        send(8'h03); send(8'h01);
        async_reset();
        send(8'h30); send(8'h01); send(8'h77);
        check_eq("t6_post_reset_data", 32'(bus.out_data), 32'h77);

        // Random frames; table may change anywhere, including mid-frame
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < NI; i++) tbl[i] = 8'($urandom_range(0, 7) + 8'h10);
                id_en = 4'($urandom);
            end
            pick = $urandom_range(0, 3);
            if (pick == 0) id = 8'hFF;
            else if (pick == 3) id = 8'($urandom);
            else id = tbl[$urandom_range(0, NI - 1)];
            len = $urandom_range(0, 6);
            for (int b = 0; b < len + 2; b++) begin
                if (b == 0) send(id);
                else if (b == 1) send(8'(len));
                else send(8'($urandom));
                if ($urandom_range(0, 19) == 0) tbl[$urandom_range(0, NI - 1)] = 8'($urandom);
                pick = $urandom_range(0, 99);
                if (pick < 6) gap = TO - 1;
                else if (pick < 10) gap = $urandom_range(TO, TO + 5);
                else gap = $urandom_range(0, 3);
                idle(gap);
                if ($urandom_range(0, 199) == 0) async_reset();
            end
        end
        bc_dummy = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
